vga_sync_gen: RTL
=================

# vga_sync_gen

VGA raster timing generator for the BAM status display. It drives the pixel counters, blanking and area qualifiers consumed by the RGB generator. It also produces DAC-aligned sync and blank strobes, plus a once-per-frame content-update pulse. It runs from the 27 MHz pixel clock and produces a 640x480 visible raster at 59.94 Hz inside an 858x525 total raster.

## Interface
- H_SYNC, 96: hsync pulse width, clocks
- H_BACK, 46: horizontal back porch; active columns start at hcnt 142
- H_ACTIVE, 640: visible columns
- H_TOTAL, 858: clocks per line
- V_SYNC, 2: vsync pulse width, lines
- V_BACK, 32: vertical back porch; active rows start at vcnt 34
- V_ACTIVE, 480: visible rows
- V_TOTAL, 525: lines per frame
- IMG_X0, 256 / IMG_Y0, 160: image window origin, relative to the active area
- IMG_W, 128 / IMG_H, 160: image window size
- SYNC_DELAY, 2: pipeline depth (1..4) matching RGB-path latency
- i_clk_27  in  1  pixel clock, 27 MHz
- i_arst  in  1  reset; asynchronous, active-low
- i_on  in  1  display enable
- i_update  in  1  one-cycle request for a text/image content refresh
- o_hcnt  out  10  horizontal counter, 0..H_TOTAL-1
- o_vcnt  out  10  vertical counter, 0..V_TOTAL-1
- o_blank_n  out  1  1 = visible pixel; aligned with o_hcnt/o_vcnt
- o_active_area  out  1  inside the 640x480 text area; aligned with counters
- o_image_active  out  1  inside the image window; aligned with counters
- o_new_data  out  1  one-cycle refresh strobe
- o_hsync  out  1  active-low; delayed SYNC_DELAY clocks
- o_vsync  out  1  active-low; delayed SYNC_DELAY clocks
- o_dac_blank_n  out  1  o_blank_n delayed SYNC_DELAY clocks

## Operation
- Reset values:
  - all counters 0
  - o_hsync = 1, o_vsync = 1
  - o_blank_n, o_dac_blank_n, o_active_area, o_image_active, o_new_data = 0
  - sync delay line filled with inactive values
  - update-pending flag cleared
- Horizontal counter: o_hcnt increments every clock and wraps from H_TOTAL-1 to 0.
- Vertical counter: o_vcnt increments on each horizontal wrap and wraps from V_TOTAL-1 to 0.
- hsync (pre-delay) is low for hcnt 0..H_SYNC-1. vsync (pre-delay) is low for vcnt 0..V_SYNC-1.
- Active area: hcnt in [142, 781] and vcnt in [34, 513]. o_blank_n equals o_active_area.
- Image window: hcnt in [142+IMG_X0, 142+IMG_X0+IMG_W-1] and vcnt in [34+IMG_Y0, 34+IMG_Y0+IMG_H-1]. o_image_active is therefore always a subset of o_active_area.
- Qualifiers are registered decodes of the next counter values, so they are valid in the same cycle as the matching o_hcnt/o_vcnt.
- Refresh handling:
  - i_update sets the pending flag.
  - At hcnt=0, vcnt=514 (first line after the active area), a set pending flag produces o_new_data=1 for exactly one cycle and clears the flag.
  - If i_update coincides with the release cycle, the flag stays set and the next frame issues the next strobe.
- i_on=0:
  - counters forced to 0
  - qualifiers, o_blank_n and o_new_data forced to 0
  - pre-delay syncs forced to 1; the delay line drains to inactive
  - pending flag retained
- i_on rising edge: the raster restarts from (0,0) on the next clock.
- Parameter legality is checked at elaboration: H_SYNC+H_BACK+H_ACTIVE < H_TOTAL, V_SYNC+V_BACK+V_ACTIVE < V_TOTAL, and the image window lies inside the active area.

## Timing
- Counters and qualifiers have zero latency relative to each other.
- o_hsync, o_vsync and o_dac_blank_n lag the counter-aligned decode by exactly SYNC_DELAY clocks.
- Line period: 858 clocks. Frame period: 450450 clocks.
- o_new_data is a one-clock pulse, at most once per frame.
- Asynchronous reset mid-line or mid-frame takes effect immediately. The first post-reset clock yields hcnt=1.

## Configuration
- VGA_SYNC_FRAME_CNT_EN defined:
  - adds output o_frame_cnt (16 bits)
  - increments on the vcnt wrap from 524 to 0, wrapping 0xFFFF to 0
  - reset value 0; holds while i_on=0
- Macro undefined: the port and its logic are absent, and all other behaviour is identical.

## Structure
- Shared package vga_timing_pkg holds:
  - the default H_*/V_* constants, including the active-start offsets 142 and 34
  - the 10-bit counter width constant
- The RGB generator imports the same package.
- One sub-module, vga_sync_delay: a parametric SYNC_DELAY-stage shift register carrying {hsync, vsync, blank_n}, with a reset value of {1,1,0}.

## Test plan
- Reset release with i_on=1 → hsync low exactly 96 of every 858 clocks; o_vsync low for 2 lines (1716 clocks) per 450450.
- Counter sampling → o_active_area first rises at hcnt=142, vcnt=34; last high at hcnt=781, vcnt=513; 307200 active clocks per frame.
- Image window with default parameters → o_image_active high for 20480 clocks per frame, first at hcnt=398, vcnt=194.
- i_update at vcnt=100 → o_new_data is a single pulse at hcnt=0, vcnt=514. A second i_update in that same release cycle → a second pulse one frame later.
- SYNC_DELAY=2 → o_hsync falls 2 clocks after hcnt wraps to 0; o_dac_blank_n rises 2 clocks after o_blank_n.
- i_on dropped mid-frame for 1000 clocks, then restored → counters read 0 throughout, syncs inactive after 2 clocks, raster restarts at (0,0). A pending update survives and is released at the next vcnt=514.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared raster constants and helpers for the
// BAM status display (sync generator and RGB generator).
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_SYNC_D   = 96;
  localparam int H_BACK_D   = 46;
  localparam int H_ACTIVE_D = 640;
  localparam int H_TOTAL_D  = 858;

  localparam int V_SYNC_D   = 2;
  localparam int V_BACK_D   = 32;
  localparam int V_ACTIVE_D = 480;
  localparam int V_TOTAL_D  = 525;

  localparam int H_ACT_START_D = 142;
  localparam int V_ACT_START_D = 34;

  localparam int IMG_X0_D = 256;
  localparam int IMG_Y0_D = 160;
  localparam int IMG_W_D  = 128;
  localparam int IMG_H_D  = 160;

  localparam int SYNC_DELAY_D = 2;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
  } sync_bus_t;

  localparam sync_bus_t SYNC_IDLE = '{
    hsync:   1'b1,
    vsync:   1'b1,
    blank_n: 1'b0
  };

  function automatic logic in_rng(
    input logic [CNT_W-1:0] c,
    input int               lo,
    input int               hi
  );
    return (int'(c) >= lo) && (int'(c) <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_delay.sv
// vga_sync_delay: DEPTH-stage shift register for {hsync, vsync, blank_n}
// so DAC strobes line up with the RGB pipeline.
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = SYNC_DELAY_D
) (
  input  logic      i_clk_27,
  input  logic      i_arst,
  input  sync_bus_t i_d,
  output sync_bus_t o_q
);

  sync_bus_t r_pipe [DEPTH];

  // Shift the strobes one stage per clock; reset fills with idle levels.
  always_ff @(posedge i_clk_27 or negedge i_arst) begin
    if (!i_arst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe[i] <= SYNC_IDLE;
      end
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster counters, qualifiers, refresh strobe, delayed syncs.
// Define VGA_SYNC_FRAME_CNT_EN to add the 16-bit o_frame_cnt output.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC     = H_SYNC_D,
  parameter int H_BACK     = H_BACK_D,
  parameter int H_ACTIVE   = H_ACTIVE_D,
  parameter int H_TOTAL    = H_TOTAL_D,
  parameter int V_SYNC     = V_SYNC_D,
  parameter int V_BACK     = V_BACK_D,
  parameter int V_ACTIVE   = V_ACTIVE_D,
  parameter int V_TOTAL    = V_TOTAL_D,
  parameter int IMG_X0     = IMG_X0_D,
  parameter int IMG_Y0     = IMG_Y0_D,
  parameter int IMG_W      = IMG_W_D,
  parameter int IMG_H      = IMG_H_D,
  parameter int SYNC_DELAY = SYNC_DELAY_D
) (
  input  logic             i_clk_27,
  input  logic             i_arst,
  input  logic             i_on,
  input  logic             i_update,
  output logic [CNT_W-1:0] o_hcnt,
  output logic [CNT_W-1:0] o_vcnt,
  output logic             o_blank_n,
  output logic             o_active_area,
  output logic             o_image_active,
  output logic             o_new_data,
  output logic             o_hsync,
  output logic             o_vsync,
`ifdef VGA_SYNC_FRAME_CNT_EN
  output logic             o_dac_blank_n,
  output logic [15:0]      o_frame_cnt
`else
  output logic             o_dac_blank_n
`endif
);

  localparam int H_A0 = H_SYNC + H_BACK;
  localparam int H_A1 = H_A0 + H_ACTIVE - 1;
  localparam int V_A0 = V_SYNC + V_BACK;
  localparam int V_A1 = V_A0 + V_ACTIVE - 1;
  localparam int I_X0 = H_A0 + IMG_X0;
  localparam int I_X1 = I_X0 + IMG_W - 1;
  localparam int I_Y0 = V_A0 + IMG_Y0;
  localparam int I_Y1 = I_Y0 + IMG_H - 1;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_REL  = CNT_W'(V_A1 + 1);

  if (H_SYNC + H_BACK + H_ACTIVE >= H_TOTAL) begin : g_bad_h
    $error("vga_sync_gen: horizontal timing exceeds H_TOTAL");
  end
  if (V_SYNC + V_BACK + V_ACTIVE >= V_TOTAL) begin : g_bad_v
    $error("vga_sync_gen: vertical timing exceeds V_TOTAL");
  end
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_w
    $error("vga_sync_gen: totals do not fit the counter width");
  end
  if (IMG_W < 1 || IMG_X0 < 0 || IMG_X0 + IMG_W > H_ACTIVE) begin : g_bad_ix
    $error("vga_sync_gen: image window outside active columns");
  end
  if (IMG_H < 1 || IMG_Y0 < 0 || IMG_Y0 + IMG_H > V_ACTIVE) begin : g_bad_iy
    $error("vga_sync_gen: image window outside active rows");
  end
  if (SYNC_DELAY < 1 || SYNC_DELAY > 4) begin : g_bad_d
    $error("vga_sync_gen: SYNC_DELAY must be 1..4");
  end

  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic [CNT_W-1:0] w_hnext;
  logic [CNT_W-1:0] w_vnext;
  logic             w_hwrap;
  logic             w_fwrap;

  logic w_act;
  logic w_img;
  logic w_hs;
  logic w_vs;
  logic w_rel;
  logic w_fire;

  logic r_active;
  logic r_image;
  logic r_hs;
  logic r_vs;
  logic r_pend;
  logic r_new_data;

  sync_bus_t w_pre;
  sync_bus_t w_dly;

  // Next raster position; parked at the origin while the display is off.
  always_comb begin
    w_hnext = '0;
    w_vnext = '0;
    w_fwrap = 1'b0;
    w_hwrap = (r_hcnt == H_LAST);
    if (i_on) begin
      if (w_hwrap) begin
        w_fwrap = (r_vcnt == V_LAST);
        w_vnext = w_fwrap ? '0 : r_vcnt + 1'b1;
      end else begin
        w_hnext = r_hcnt + 1'b1;
        w_vnext = r_vcnt;
      end
    end
  end

  // Decode the next position so registered qualifiers match the counters.
  always_comb begin
    w_act = 1'b0;
    w_img = 1'b0;
    w_hs  = 1'b1;
    w_vs  = 1'b1;
    w_rel = 1'b0;
    if (i_on) begin
      w_act = in_rng(w_hnext, H_A0, H_A1)
           && in_rng(w_vnext, V_A0, V_A1);
      w_img = in_rng(w_hnext, I_X0, I_X1)
           && in_rng(w_vnext, I_Y0, I_Y1);
      w_hs  = !in_rng(w_hnext, 0, H_SYNC - 1);
      w_vs  = !in_rng(w_vnext, 0, V_SYNC - 1);
      w_rel = (w_hnext == '0) && (w_vnext == V_REL);
    end
  end

  assign w_fire = w_rel && r_pend;

  // Raster counters.
  always_ff @(posedge i_clk_27 or negedge i_arst) begin
    if (!i_arst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      r_hcnt <= w_hnext;
      r_vcnt <= w_vnext;
    end
  end

  // Counter-aligned qualifiers and pre-delay syncs.
  always_ff @(posedge i_clk_27 or negedge i_arst) begin
    if (!i_arst) begin
      r_active <= 1'b0;
      r_image  <= 1'b0;
      r_hs     <= 1'b1;
      r_vs     <= 1'b1;
    end else begin
      r_active <= w_act;
      r_image  <= w_img;
      r_hs     <= w_hs;
      r_vs     <= w_vs;
    end
  end

  // Refresh request latch; released on the first line below the text area.
  // A request landing on the release edge survives for the next frame.
  always_ff @(posedge i_clk_27 or negedge i_arst) begin
    if (!i_arst) begin
      r_pend     <= 1'b0;
      r_new_data <= 1'b0;
    end else begin
      r_pend     <= i_update || (r_pend && !w_fire);
      r_new_data <= w_fire;
    end
  end

  assign w_pre = '{hsync: r_hs, vsync: r_vs, blank_n: r_active};

  vga_sync_delay #(
    .DEPTH (SYNC_DELAY)
  ) u_dly (
    .i_clk_27 (i_clk_27),
    .i_arst   (i_arst),
    .i_d      (w_pre),
    .o_q      (w_dly)
  );

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Count completed frames; holds while the raster is parked.
  always_ff @(posedge i_clk_27 or negedge i_arst) begin
    if (!i_arst) begin
      r_frame_cnt <= '0;
    end else if (w_fwrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`endif

  assign o_hcnt         = r_hcnt;
  assign o_vcnt         = r_vcnt;
  assign o_blank_n      = r_active;
  assign o_active_area  = r_active;
  assign o_image_active = r_image;
  assign o_new_data     = r_new_data;
  assign o_hsync        = w_dly.hsync;
  assign o_vsync        = w_dly.vsync;
  assign o_dac_blank_n  = w_dly.blank_n;

endmodule
